uart_rx: RTL

UART receiver for the peripheral subsystem; the receive-side counterpart of the 16x-oversampled UART transmitter sharing `uart_clk`. Deserialises 8N1 frames (start, 8 data LSB-first, stop) from the asynchronous `rxd` pin. Presents each good byte with a one-cycle valid pulse to the peripheral register file, and flags framing errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 45 ++++
 rtl/uart_rx.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding, common to the receiver and transmitter.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam logic [3:0]  UART_MID        = 4'd7;
  localparam logic [3:0]  UART_LAST       = 4'd15;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchroniser, history flop and sample filter for uart_rx.
// UART_RX_MAJORITY_EN: smp is the 2-of-3 majority of the last three synchronised values.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic uart_clk,
  input  logic reset,
  input  logic rxd,
  output logic rxs,
  output logic rxs_d,
  output logic smp
);

  logic sync1;

  // Idle-high reset values: the line must show a real 1->0 edge after reset.
  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      hist <= '1;
    end else begin
      hist <= {hist[0], rxs};
    end
  end

  assign smp = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign smp = rxs;
`endif

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with one-cycle data-valid and framing-error pulses.
// Optional UART_RX_MAJORITY_EN enables the majority sample filter in uart_rx_sync.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       reset,
  input  logic       uart_clk,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [3:0] BIT_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic rxs, rxs_d, smp;

  uart_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  bitidx, bitidx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data_nxt;
  logic        status_nxt, ferr_nxt;

  uart_rx_sync u_sync (
    .uart_clk (uart_clk),
    .reset    (reset),
    .rxd      (rxd),
    .rxs      (rxs),
    .rxs_d    (rxs_d),
    .smp      (smp)
  );

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bitidx       <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_status    <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bitidx       <= bitidx_nxt;
      shreg        <= shreg_nxt;
      rx_data      <= data_nxt;
      rx_status    <= status_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 4'd1;
    bitidx_nxt = bitidx;
    shreg_nxt  = shreg;
    data_nxt   = rx_data;
    status_nxt = 1'b0;
    ferr_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rxs_d && !rxs) state_nxt = START;
      end
      START: begin
        if (cnt == BIT_MID) begin
          cnt_nxt    = '0;
          bitidx_nxt = '0;
          state_nxt  = smp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt           = '0;
          shreg_nxt[bitidx] = smp;
          bitidx_nxt        = bitidx + 3'd1;
          if (bitidx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop-bit lets a back-to-back start edge through.
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (smp) begin
            data_nxt   = shreg;
            status_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule
